// File: rtl/listing_loader_if.sv
// rtl/listing_loader_if.sv - host byte stream and CPU memory write port for listing_loader
// Purpose: bundles the loader's byte-stream handshake and its memory write port.
// Signals:
//   in_valid, in_data[7:0], in_last : host -> loader byte stream
//   in_ready                        : loader -> host, byte accepted this cycle
//   mem_wr_en, mem_addr[15:0], mem_wr_data[7:0] : loader -> CPU memory write port
// Modports: master = host/memory side, slave = loader side.
interface listing_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        mem_wr_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wr_data;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_wr_en, mem_addr, mem_wr_data
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_wr_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/listing_loader.sv
// rtl/listing_loader.sv - loads address/data records or a raw program image into CPU memory
// Purpose: parses a host byte stream either as 3-byte records (addr hi, addr lo, data)
//   or as a raw image placed from PROG_BASE, issuing single-cycle memory writes while
//   holding the CPU off the bus.
// Parameters: PROG_BASE - start address for program mode.
// Ports:
//   clk, rst_n (async, active low)
//   start, mode     : load request pulse and mode (0 = records, 1 = program image)
//   bus (slave)     : byte stream in, memory write port out
//   busy, cpu_hold  : load in progress / CPU stall request (identical)
//   done            : one-cycle end-of-load pulse
//   err             : sticky error, cleared on the next accepted start
//   wr_count        : memory writes since the last accepted start
// Build option: LOADER_CHECKSUM_EN - the in_last byte is an 8-bit checksum byte
//   (running sum of all accepted bytes must be 8'h00) instead of payload.
module listing_loader #(
  parameter logic [15:0] PROG_BASE = 16'h0200
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            mode,
  listing_loader_if.slave bus,
  output logic            busy,
  output logic            cpu_hold,
  output logic            done,
  output logic            err,
  output logic [15:0]     wr_count
);

  typedef enum logic [2:0] {IDLE, HI, LO, DAT, WR, FIN} state_t;

  state_t      state;
  logic        mode_r;
  logic        last_r;   // the data byte just written was the final stream byte
  logic [15:0] addr_r;
  logic        accept;

  assign accept   = bus.in_valid && bus.in_ready;
  assign cpu_hold = busy;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_r;
  logic [7:0] sum_next;
  assign sum_next = sum_r + bus.in_data;
`endif

  // in_ready, mem_wr_en and done are registered: each is set on the edge that
  // enters the state in which it must be visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      mode_r          <= 1'b0;
      last_r          <= 1'b0;
      addr_r          <= '0;
      bus.in_ready    <= 1'b0;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wr_data <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      wr_count        <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_r           <= '0;
`endif
    end else begin
      bus.mem_wr_en <= 1'b0;
      done          <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      if (accept) sum_r <= sum_next;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            mode_r       <= mode;
            wr_count     <= '0;
            err          <= 1'b0;
            busy         <= 1'b1;
            last_r       <= 1'b0;
            bus.in_ready <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_r        <= '0;
`endif
            if (mode) begin
              addr_r <= PROG_BASE;
              state  <= DAT;
            end else begin
              state  <= HI;
            end
          end
        end
        HI: begin
          if (accept) begin
            addr_r[15:8] <= bus.in_data;
            if (bus.in_last) begin
              bus.in_ready <= 1'b0;
              done         <= 1'b1;
              state        <= FIN;
`ifdef LOADER_CHECKSUM_EN
              // Checksum byte at a record boundary is legal; only the sum decides.
              if (sum_next != 8'h00) err <= 1'b1;
`else
              err <= 1'b1;
`endif
            end else begin
              state <= LO;
            end
          end
        end
        LO: begin
          if (accept) begin
            addr_r[7:0] <= bus.in_data;
            if (bus.in_last) begin
              bus.in_ready <= 1'b0;
              done         <= 1'b1;
              err          <= 1'b1;
              state        <= FIN;
            end else begin
              state <= DAT;
            end
          end
        end
        DAT: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            if (bus.in_last) begin
              done  <= 1'b1;
              state <= FIN;
              // In record mode the checksum may not replace a record's data byte.
              if (!mode_r || sum_next != 8'h00) err <= 1'b1;
            end else begin
              bus.mem_wr_en   <= 1'b1;
              bus.mem_addr    <= addr_r;
              bus.mem_wr_data <= bus.in_data;
              state           <= WR;
            end
`else
            last_r          <= bus.in_last;
            bus.mem_wr_en   <= 1'b1;
            bus.mem_addr    <= addr_r;
            bus.mem_wr_data <= bus.in_data;
            state           <= WR;
`endif
          end
        end
        WR: begin
          wr_count <= wr_count + 16'd1;
          if (last_r) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            bus.in_ready <= 1'b1;
            if (mode_r) begin
              addr_r <= addr_r + 16'd1;
              state  <= DAT;
            end else begin
              state  <= HI;
            end
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_listing_loader.sv
// tb/tb_listing_loader.sv - self-checking bench for listing_loader
module tb_listing_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mode, busy, cpu_hold, done, err;
  logic [15:0] wr_count;
  logic        start1, mode1, busy1, cpu_hold1, done1, err1;
  logic [15:0] wr_count1;

  listing_loader_if bus();
  listing_loader_if bus1();

  listing_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .bus(bus),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err), .wr_count(wr_count)
  );

  listing_loader #(.PROG_BASE(16'hFFFF)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .bus(bus1),
    .busy(busy1), .cpu_hold(cpu_hold1), .done(done1), .err(err1), .wr_count(wr_count1)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: what a whole load must produce, from the stream alone.
  logic [7:0]  st_data[$];
  bit          wr_flag[$];
  logic [23:0] exp_wr_q[$];
  logic [23:0] log_q[$];
  logic [23:0] log1_q[$];
  bit          exp_err;
  int          exp_cnt;

  function automatic void build_model(input bit m, input logic [15:0] base);
    int n;
    int plen;
    logic [7:0] s;
    n = st_data.size();
    wr_flag.delete();
    exp_wr_q.delete();
    exp_err = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    plen = n - 1;
    s = 8'h00;
    foreach (st_data[i]) s = s + st_data[i];
    if (s != 8'h00) exp_err = 1'b1;
    if (!m && (plen % 3) != 0) exp_err = 1'b1;
`else
    plen = n;
    s = 8'h00;
    if (!m && (n % 3) != 0) exp_err = 1'b1;
`endif
    for (int i = 0; i < n; i++) begin
      bit w;
      w = (i < plen) && (m || (i % 3 == 2));
      wr_flag.push_back(w);
      if (w) begin
        if (m) exp_wr_q.push_back({base + 16'(i), st_data[i]});
        else   exp_wr_q.push_back({st_data[i-2], st_data[i-1], st_data[i]});
      end
    end
    exp_cnt = exp_wr_q.size();
  endfunction

  // Per-cycle compare against the model's timing rules.
  int byte_idx = 0;
  bit pend_wr  = 1'b0;
  int done_in  = 0;
  bit exp_busy = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      byte_idx = 0;
      pend_wr  = 1'b0;
      done_in  = 0;
      exp_busy = 1'b0;
    end else begin
      check("cpu_hold", 32'(cpu_hold), 32'(busy));
      check("busy", 32'(busy), 32'(exp_busy));
      check("mem_wr_en", 32'(bus.mem_wr_en), 32'(pend_wr));
      if (bus.mem_wr_en) begin
        log_q.push_back({bus.mem_addr, bus.mem_wr_data});
        if (exp_wr_q.size() == 0) fail_now("unexpected_write");
        else check("write_addr_data", 32'({bus.mem_addr, bus.mem_wr_data}), 32'(exp_wr_q.pop_front()));
      end
      check("done", 32'(done), 32'(done_in == 1));
      if (done) begin
        check("err_at_done", 32'(err), 32'(exp_err));
        check("wr_count_at_done", 32'(wr_count), 32'(exp_cnt));
      end
      pend_wr = 1'b0;
      if (start && !exp_busy) begin
        exp_busy = 1'b1;
        byte_idx = 0;
      end
      if (done_in == 1) exp_busy = 1'b0;
      if (done_in > 0) done_in--;
      if (bus.in_valid && bus.in_ready) begin
        if (byte_idx < wr_flag.size()) begin
          pend_wr = wr_flag[byte_idx];
          if (byte_idx == wr_flag.size() - 1) done_in = wr_flag[byte_idx] ? 2 : 1;
        end
        byte_idx++;
      end
    end
  end

  always @(negedge clk) if (bus1.mem_wr_en) log1_q.push_back({bus1.mem_addr, bus1.mem_wr_data});

  task automatic run_load(input bit m, input bit gaps, input int abort_at, input bit poke_start);
    int tmo;
    build_model(m, 16'h0200);
    log_q.delete();
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 1'($urandom);
    check("ready_after_start", 32'({busy, bus.in_ready}), 32'h3);
    for (int i = 0; i < st_data.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          bus.in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = st_data[i];
      bus.in_last  = (i == st_data.size() - 1);
      if (poke_start && i == 1) begin
        start = 1'b1;
        mode  = ~m;
      end
      tmo = 0;
      forever begin
        @(negedge clk);
        if (bus.in_ready) break;
        @(posedge clk); #1;
        start = 1'b0;
        tmo++;
        if (tmo > 40) begin
          fail_now("in_ready_timeout");
          bus.in_valid = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (i == abort_at) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'({busy, cpu_hold}), 32'h0);
        check("abort_ready_wr", 32'({bus.in_ready, bus.mem_wr_en, done, err}), 32'h0);
        check("abort_count_addr", 32'({wr_count, bus.mem_addr}), 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_write", 32'(log_q.size()), 32'h0);
        return;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    tmo = 0;
    do begin
      @(negedge clk);
      tmo++;
    end while (!done && tmo < 20);
    if (!done) fail_now("done_timeout");
    @(posedge clk); #1;
    check("err_sticky_after_done", 32'(err), 32'(exp_err));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit m;
    logic [7:0] s;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
    start1 = 1'b0; mode1 = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = 8'h00; bus1.in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", 32'({busy, cpu_hold, done, err, bus.in_ready, bus.mem_wr_en}), 32'h0);
    check("reset_values", 32'({wr_count, bus.mem_addr}), 32'h0);
    check("reset_wr_data", 32'(bus.mem_wr_data), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifndef LOADER_CHECKSUM_EN
    st_data = '{8'h02, 8'h00, 8'hA2, 8'h02, 8'h01, 8'h00};
    run_load(1'b0, 1'b0, -1, 1'b0);
    check("rec_nwr", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check("rec_wr0", 32'(log_q[0]), 32'h0200A2);
      check("rec_wr1", 32'(log_q[1]), 32'h020100);
    end
    check("rec_err_count", 32'({err, wr_count}), 32'h00002);

    st_data = '{8'hA2, 8'h00, 8'h8A};
    run_load(1'b1, 1'b0, -1, 1'b0);
    check("prog_nwr", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      check("prog_wr0", 32'(log_q[0]), 32'h0200A2);
      check("prog_wr1", 32'(log_q[1]), 32'h020100);
      check("prog_wr2", 32'(log_q[2]), 32'h02028A);
    end

    st_data = '{8'h00, 8'h1E};
    run_load(1'b0, 1'b0, -1, 1'b0);
    check("trunc_nwr", 32'(log_q.size()), 32'd0);
    check("trunc_err_count", 32'({err, wr_count}), 32'h10000);
`else
    st_data = '{8'hA2, 8'h00, 8'h5E};
    run_load(1'b1, 1'b0, -1, 1'b0);
    check("ck_nwr", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      check("ck_wr0", 32'(log_q[0]), 32'h0200A2);
      check("ck_wr1", 32'(log_q[1]), 32'h020100);
    end
    check("ck_good_err", 32'(err), 32'h0);
    st_data = '{8'hA2, 8'h00, 8'h5F};
    run_load(1'b1, 1'b0, -1, 1'b0);
    check("ck_bad_err", 32'(err), 32'h1);
`endif

    // Gapped stream and a start pulse landing mid-load.
    st_data = '{8'h12, 8'h34, 8'h56, 8'h12, 8'h35, 8'h78, 8'h00};
    run_load(1'b0, 1'b1, -1, 1'b1);
    st_data = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_load(1'b1, 1'b1, -1, 1'b1);

    // Reset while waiting for a record's data byte.
    st_data = '{8'h12, 8'h34, 8'h56};
    run_load(1'b0, 1'b0, 1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      m = 1'($urandom);
      n = $urandom_range(1, 10);
      st_data.delete();
      s = 8'h00;
      for (int i = 0; i < n; i++) begin
        st_data.push_back(8'($urandom));
        s = s + st_data[i];
      end
      if ($urandom_range(0, 1) == 1) st_data[n-1] = st_data[n-1] - s;
      run_load(m, 1'($urandom), -1, ($urandom_range(0, 3) == 0));
    end

    // Program-mode address wrap on an instance based at 16'hFFFF.
    log1_q.delete();
    mode1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      int tmo;
      bus1.in_valid = 1'b1;
      bus1.in_data  = (i == 0) ? 8'h11 : 8'h22;
      bus1.in_last  = (i == 1);
      tmo = 0;
      forever begin
        @(negedge clk);
        if (bus1.in_ready || tmo > 20) break;
        @(posedge clk); #1;
        tmo++;
      end
      if (!bus1.in_ready) fail_now("wrap_ready_timeout");
      @(posedge clk); #1;
    end
    bus1.in_valid = 1'b0;
    bus1.in_last  = 1'b0;
    repeat (6) @(posedge clk);
    #1;
`ifndef LOADER_CHECKSUM_EN
    check("wrap_nwr", 32'(log1_q.size()), 32'd2);
    if (log1_q.size() == 2) begin
      check("wrap_wr0", 32'(log1_q[0]), 32'hFFFF11);
      check("wrap_wr1", 32'(log1_q[1]), 32'h000022);
    end
    check("wrap_count", 32'(wr_count1), 32'd2);
`else
    check("wrap_nwr", 32'(log1_q.size()), 32'd1);
    if (log1_q.size() == 1) check("wrap_wr0", 32'(log1_q[0]), 32'hFFFF11);
`endif
    check("wrap_idle", 32'({busy1, cpu_hold1}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
